qcw_ocd_multi: RTL and testbench
================================

QCW_OCD_MULTI -- requirements
Module: qcw_ocd_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of independent current-sense channels (1..8).
REQ-002 SHALL have parameter ADC_WIDTH, default 10, bits per ADC sample.
REQ-003 SHALL have parameter DEBOUNCE, default 3, consecutive over-limit samples needed to trip (>=1).
REQ-004 SHALL have parameter BLANK_CYCLES, default 16, clk cycles after start during which trips are suppressed (>=0).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port adc_valid  input  1  qualifies adc_data for one clk cycle.
REQ-008 SHALL have port adc_data  input  CHANNELS*ADC_WIDTH  unsigned samples; channel k at bits [k*ADC_WIDTH +: ADC_WIDTH].
REQ-009 SHALL have port trip_limit  input  CHANNELS*ADC_WIDTH  per-channel unsigned limit, same packing.
REQ-010 SHALL have port qcw_start  input  1  single-cycle burst-start pulse.
REQ-011 SHALL have port qcw_done  input  1  single-cycle burst-end pulse.
REQ-012 SHALL have port clear_fault  input  1  single-cycle fault-release pulse.
REQ-013 SHALL have port qcw_halt  output  1  registered halt request to the gate-drive block.
REQ-014 SHALL have port fault_chan  output  CHANNELS  latched one-hot/multi-hot mask of tripping channels.
REQ-015 SHALL have port current_max  output  CHANNELS*ADC_WIDTH  per-channel burst peak, same packing.
REQ-016 SHALL have port armed  output  1  high in ARMED state only.

Function
REQ-017 SHALL implement states IDLE, BLANK, ARMED, TRIPPED.
REQ-018 IDLE: qcw_start -> BLANK; clears current_max, fault_chan, all debounce counters; loads blank counter with BLANK_CYCLES.
REQ-019 BLANK: blank counter decrements each clk; at zero -> ARMED; BLANK_CYCLES=0 enters ARMED on the cycle after start.
REQ-020 ARMED: per channel, adc_valid with sample > limit (strict) increments saturating debounce counter; adc_valid with sample <= limit clears it; no adc_valid holds it.
REQ-021 ARMED: any counter reaching DEBOUNCE -> TRIPPED; qcw_halt asserts on the clk edge after that sample is registered (one cycle latency from the sampling edge); fault_chan latches every channel reaching DEBOUNCE that cycle.
REQ-022 BLANK or ARMED: qcw_done -> IDLE; trip condition in the same cycle as qcw_done takes priority (-> TRIPPED).
REQ-023 BLANK or ARMED: qcw_start restarts as in REQ-018 (re-blank, clear peaks).
REQ-024 TRIPPED: qcw_halt held high; qcw_start and qcw_done ignored; clear_fault -> IDLE, qcw_halt low next cycle; fault_chan retained until next qcw_start.
REQ-025 clear_fault outside TRIPPED SHALL have no effect.
REQ-026 Peak: in BLANK and ARMED, adc_valid with sample > current_max[k] updates current_max[k]; held in IDLE and TRIPPED.
REQ-027 trip_limit all-ones SHALL disable that channel (strict compare never true).
REQ-028 Debounce counters SHALL be $clog2(DEBOUNCE+1) bits, saturating, never wrapping.
REQ-029 trip_limit SHALL be sampled live each cycle (not latched at start).

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE, qcw_halt=0, armed=0, fault_chan=0, current_max=0, all counters 0.
REQ-031 Reset deassertion mid-burst SHALL leave the block in IDLE awaiting a new qcw_start.

Structure
REQ-032 Shared package qcw_pkg SHALL hold the state enum type and the default parameter constants.
REQ-033 Per-channel compare/debounce/peak logic SHALL be sub-module qcw_ocd_channel, instantiated CHANNELS times via generate; FSM stays in qcw_ocd_multi.

Verification (CHANNELS=2, ADC_WIDTH=10, DEBOUNCE=3, BLANK_CYCLES=16, limits 640)
REQ-034 Start, then ch0=700 on every valid sample from cycle 2 -> no halt during blank; halt rises 1 cycle after 3rd valid sample in ARMED; fault_chan=2'b01.
REQ-035 ARMED, ch1 samples 700,700,600,700,700 -> no trip; then one more 700 -> trip, fault_chan=2'b10.
REQ-036 ARMED, both channels 3x800 same cycles -> fault_chan=2'b11; clear_fault -> halt low next cycle, state IDLE, fault_chan still 2'b11 until next start.
REQ-037 Burst with ch0 peak 512, ch1 peak 300, qcw_done -> current_max={300,512} held; next start -> both 0.
REQ-038 Third over-limit sample coincident with qcw_done -> TRIPPED, halt=1; trip_limit=1023 with samples 1023 -> never trips.
REQ-039 reset_n pulsed low while TRIPPED -> halt=0, all outputs 0 immediately, no clk edge required.

Source files
------------

// File: rtl/qcw_pkg.sv
// rtl/qcw_pkg.sv - shared state type and default parameters for the QCW over-current detector
// Contents: qcw_state_t (controller states), DEF_* default parameter values.
package qcw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BLANK   = 2'd1,
        ST_ARMED   = 2'd2,
        ST_TRIPPED = 2'd3
    } qcw_state_t;

    localparam int DEF_CHANNELS     = 2;
    localparam int DEF_ADC_WIDTH    = 10;
    localparam int DEF_DEBOUNCE     = 3;
    localparam int DEF_BLANK_CYCLES = 16;

endpackage

// File: rtl/qcw_ocd_channel.sv
// rtl/qcw_ocd_channel.sv - one current-sense channel: limit compare, debounce counter, burst peak
// Ports: clk, reset_n (async active-low); restart clears counter and peak;
//        arm_en enables debounce counting; peak_en enables peak tracking;
//        adc_valid/sample/limit are the live inputs; hit flags the counter reaching
//        DEBOUNCE on this cycle's sample; peak is the registered burst maximum.
module qcw_ocd_channel
    import qcw_pkg::*;
#(
    parameter int ADC_WIDTH = DEF_ADC_WIDTH,
    parameter int DEBOUNCE  = DEF_DEBOUNCE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 restart,
    input  logic                 arm_en,
    input  logic                 peak_en,
    input  logic                 adc_valid,
    input  logic [ADC_WIDTH-1:0] sample,
    input  logic [ADC_WIDTH-1:0] limit,
    output logic                 hit,
    output logic [ADC_WIDTH-1:0] peak
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          over;

    // Strict compare: an all-ones limit can never be exceeded, disabling the channel.
    assign over    = sample > limit;
    assign cnt_inc = (cnt == DEB_MAX) ? cnt : cnt + 1'b1;
    // Combinational so the controller can trip on the very edge that samples the data,
    // which lets a trip win over a coincident burst-end pulse.
    assign hit     = arm_en && adc_valid && over && (cnt_inc == DEB_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            peak <= '0;
        end else if (restart) begin
            cnt  <= '0;
            peak <= '0;
        end else begin
            if (arm_en && adc_valid) begin
                cnt <= over ? cnt_inc : '0;
            end
            if (peak_en && adc_valid && (sample > peak)) begin
                peak <= sample;
            end
        end
    end

endmodule

// File: rtl/qcw_ocd_multi.sv
// rtl/qcw_ocd_multi.sv - multi-channel QCW burst over-current detector with blanking and fault latch
// Ports: clk, reset_n (async active-low); adc_valid/adc_data per-channel samples;
//        trip_limit per-channel live limits; qcw_start/qcw_done/clear_fault control pulses;
//        qcw_halt registered halt request; fault_chan latched tripping-channel mask;
//        current_max per-channel burst peaks; armed high only while ARMED.
module qcw_ocd_multi
    import qcw_pkg::*;
#(
    parameter int CHANNELS     = DEF_CHANNELS,
    parameter int ADC_WIDTH    = DEF_ADC_WIDTH,
    parameter int DEBOUNCE     = DEF_DEBOUNCE,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          adc_valid,
    input  logic [CHANNELS*ADC_WIDTH-1:0] adc_data,
    input  logic [CHANNELS*ADC_WIDTH-1:0] trip_limit,
    input  logic                          qcw_start,
    input  logic                          qcw_done,
    input  logic                          clear_fault,
    output logic                          qcw_halt,
    output logic [CHANNELS-1:0]           fault_chan,
    output logic [CHANNELS*ADC_WIDTH-1:0] current_max,
    output logic                          armed
);

    localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);

    qcw_state_t        state, state_nxt;
    logic [BW-1:0]     blank_cnt, blank_nxt;
    logic              restart;
    logic              trip;
    logic [CHANNELS-1:0] hit;

    assign trip  = |hit;
    assign armed = (state == ST_ARMED);

    always_comb begin
        state_nxt = state;
        blank_nxt = blank_cnt;
        restart   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (qcw_start) begin
                    restart   = 1'b1;
                    blank_nxt = BLANK_LOAD;
                    state_nxt = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (qcw_start) begin
                    restart   = 1'b1;
                    blank_nxt = BLANK_LOAD;
                end else if (qcw_done) begin
                    state_nxt = ST_IDLE;
                end else if (blank_cnt == '0) begin
                    state_nxt = ST_ARMED;
                end else begin
                    blank_nxt = blank_cnt - 1'b1;
                end
            end
            ST_ARMED: begin
                if (trip) begin
                    state_nxt = ST_TRIPPED;
                end else if (qcw_start) begin
                    restart   = 1'b1;
                    blank_nxt = BLANK_LOAD;
                    state_nxt = ST_BLANK;
                end else if (qcw_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_TRIPPED: begin
                if (clear_fault) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            blank_cnt  <= '0;
            fault_chan <= '0;
            qcw_halt   <= 1'b0;
        end else begin
            state     <= state_nxt;
            blank_cnt <= blank_nxt;
            if (restart) begin
                fault_chan <= '0;
            end else if (armed && trip) begin
                fault_chan <= hit;
            end
            // Halt follows the TRIPPED state one edge later, but drops on the same
            // edge that accepts clear_fault.
            qcw_halt <= (state == ST_TRIPPED) && !clear_fault;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        qcw_ocd_channel #(
            .ADC_WIDTH (ADC_WIDTH),
            .DEBOUNCE  (DEBOUNCE)
        ) u_chan (
            .clk       (clk),
            .reset_n   (reset_n),
            .restart   (restart),
            .arm_en    (armed),
            .peak_en   ((state == ST_BLANK) || (state == ST_ARMED)),
            .adc_valid (adc_valid),
            .sample    (adc_data[k*ADC_WIDTH +: ADC_WIDTH]),
            .limit     (trip_limit[k*ADC_WIDTH +: ADC_WIDTH]),
            .hit       (hit[k]),
            .peak      (current_max[k*ADC_WIDTH +: ADC_WIDTH])
        );
    end

endmodule

// File: tb/tb_qcw_ocd_multi.sv
// tb/tb_qcw_ocd_multi.sv - directed self-checking bench for qcw_ocd_multi
module tb_qcw_ocd_multi;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        adc_valid = 1'b0;
    logic [19:0] adc_data = '0;
    logic [19:0] trip_limit = {10'd640, 10'd640};
    logic        qcw_start = 1'b0;
    logic        qcw_done = 1'b0;
    logic        clear_fault = 1'b0;
    logic        qcw_halt;
    logic [1:0]  fault_chan;
    logic [19:0] current_max;
    logic        armed;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    qcw_ocd_multi #(
        .CHANNELS     (2),
        .ADC_WIDTH    (10),
        .DEBOUNCE     (3),
        .BLANK_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .adc_valid   (adc_valid),
        .adc_data    (adc_data),
        .trip_limit  (trip_limit),
        .qcw_start   (qcw_start),
        .qcw_done    (qcw_done),
        .clear_fault (clear_fault),
        .qcw_halt    (qcw_halt),
        .fault_chan  (fault_chan),
        .current_max (current_max),
        .armed       (armed)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the rising edge.
    task automatic cyc(input logic v, input logic [9:0] d0, input logic [9:0] d1,
                       input logic st, input logic dn, input logic cl);
        adc_valid   = v;
        adc_data    = {d1, d0};
        qcw_start   = st;
        qcw_done    = dn;
        clear_fault = cl;
        @(posedge clk);
        #1;
        adc_valid   = 1'b0;
        qcw_start   = 1'b0;
        qcw_done    = 1'b0;
        clear_fault = 1'b0;
    endtask

    task automatic arm_burst();
        cyc(0, 0, 0, 1, 0, 0);
        repeat (17) cyc(0, 0, 0, 0, 0, 0);
        chk("arm_armed", {31'd0, armed}, 32'd1);
        chk("arm_fault_clr", {30'd0, fault_chan}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_halt", {31'd0, qcw_halt}, 32'd0);
        chk("rst_armed", {31'd0, armed}, 32'd0);
        chk("rst_fault", {30'd0, fault_chan}, 32'd0);
        chk("rst_max", {12'd0, current_max}, 32'd0);
        reset_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);

        // Blanking suppresses trips; third armed sample trips, halt one edge later.
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            cyc(1, 700, 0, 0, 0, 0);
            chk("blank_halt", {31'd0, qcw_halt}, 32'd0);
            chk("blank_armed", {31'd0, armed}, {31'd0, (i >= 17 && i <= 19)});
        end
        cyc(1, 700, 0, 0, 0, 0);
        chk("t34_halt", {31'd0, qcw_halt}, 32'd1);
        chk("t34_fault", {30'd0, fault_chan}, 32'd1);
        chk("t34_max", {12'd0, current_max}, 32'd700);
        cyc(0, 0, 0, 1, 1, 0);
        chk("trip_ign_start", {31'd0, qcw_halt}, 32'd1);
        chk("trip_ign_max", {12'd0, current_max}, 32'd700);
        cyc(0, 0, 0, 0, 0, 1);
        chk("clr_halt", {31'd0, qcw_halt}, 32'd0);
        chk("clr_fault_kept", {30'd0, fault_chan}, 32'd1);

        // Debounce resets on an in-limit sample and holds across an idle cycle.
        arm_burst();
        cyc(1, 0, 700, 0, 0, 0);
        cyc(1, 0, 700, 0, 0, 0);
        cyc(1, 0, 600, 0, 0, 0);
        cyc(1, 0, 700, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 700, 0, 0, 0);
        chk("t35_no_trip", {31'd0, armed}, 32'd1);
        cyc(1, 0, 700, 0, 0, 0);
        chk("t35_tripped", {31'd0, armed}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t35_halt", {31'd0, qcw_halt}, 32'd1);
        chk("t35_fault", {30'd0, fault_chan}, 32'd2);
        cyc(0, 0, 0, 0, 0, 1);

        // Both channels trip together; fault mask survives clear until next start.
        arm_burst();
        repeat (3) cyc(1, 800, 800, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t36_halt", {31'd0, qcw_halt}, 32'd1);
        chk("t36_fault", {30'd0, fault_chan}, 32'd3);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t36_clr_halt", {31'd0, qcw_halt}, 32'd0);
        chk("t36_clr_armed", {31'd0, armed}, 32'd0);
        chk("t36_fault_kept", {30'd0, fault_chan}, 32'd3);
        cyc(0, 0, 0, 0, 0, 1);
        chk("idle_clr_fault", {30'd0, fault_chan}, 32'd3);

        // Peak capture, hold after done, clear on next start; clear_fault ignored when armed.
        arm_burst();
        cyc(0, 0, 0, 0, 0, 1);
        chk("armed_clr_ign", {31'd0, armed}, 32'd1);
        cyc(1, 200, 100, 0, 0, 0);
        cyc(1, 512, 300, 0, 0, 0);
        cyc(1, 100, 50, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("t37_done_idle", {31'd0, armed}, 32'd0);
        cyc(1, 900, 900, 0, 0, 0);
        chk("t37_max_held", {12'd0, current_max}, (32'd300 << 10) | 32'd512);
        cyc(0, 0, 0, 1, 0, 0);
        chk("t37_max_clr", {12'd0, current_max}, 32'd0);
        cyc(0, 0, 0, 0, 1, 0);

        // Trip beats coincident done.
        arm_burst();
        cyc(1, 700, 0, 0, 0, 0);
        cyc(1, 700, 0, 0, 0, 0);
        cyc(1, 700, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t38_halt", {31'd0, qcw_halt}, 32'd1);
        chk("t38_fault", {30'd0, fault_chan}, 32'd1);
        cyc(0, 0, 0, 0, 0, 1);

        // All-ones limit never trips; limit changes take effect live.
        trip_limit = {10'd640, 10'd1023};
        arm_burst();
        repeat (5) cyc(1, 1023, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("dis_armed", {31'd0, armed}, 32'd1);
        chk("dis_halt", {31'd0, qcw_halt}, 32'd0);
        chk("dis_max", {12'd0, current_max}, 32'd1023);
        trip_limit = {10'd640, 10'd640};
        repeat (3) cyc(1, 700, 0, 0, 0, 0);
        chk("live_trip", {31'd0, armed}, 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("live_halt", {31'd0, qcw_halt}, 32'd1);

        // Asynchronous reset while tripped.
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_halt", {31'd0, qcw_halt}, 32'd0);
        chk("arst_armed", {31'd0, armed}, 32'd0);
        chk("arst_fault", {30'd0, fault_chan}, 32'd0);
        chk("arst_max", {12'd0, current_max}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (20) cyc(1, 800, 800, 0, 0, 0);
        chk("post_rst_idle", {31'd0, armed}, 32'd0);
        chk("post_rst_halt", {31'd0, qcw_halt}, 32'd0);

        // Done during blanking returns to idle.
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        repeat (20) cyc(0, 0, 0, 0, 0, 0);
        chk("blank_done_idle", {31'd0, armed}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
